// File: rtl/id_ex_hazard_stage.sv
// ID->EX pipeline register with load-use hazard detection, MEM/WB operand
// forwarding and a saturating stall-cycle counter.
// Optional feature macro: FWD_EN
//   defined   : MEM/WB results forward into the EX operands; only load-use stalls.
//   undefined : EX operands are the registered RegFile buses. Any RAW against
//               EX or MEM stalls, and WB relies on the RegFile write bypass.
module id_ex_hazard_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_rt_used,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       id_busA,
    input  logic [31:0]       id_busB,
    input  logic [31:0]       id_imm,
    input  logic              id_regwr,
    input  logic              id_memrd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              mem_regwr,
    input  logic [4:0]        mem_rd,
    input  logic [31:0]       mem_result,
    input  logic              wb_regwr,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_result,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [4:0]        ex_rd,
    output logic              ex_regwr,
    output logic              ex_memrd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_imm,
    output logic [31:0]       ex_opA,
    output logic [31:0]       ex_opB,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [4:0]  exRs;
    logic [4:0]  exRt;
    logic [31:0] exBusA;
    logic [31:0] exBusB;

    logic exReadsHit;
    logic hazard;
    logic loadBubble;

    // ID reads the EX destination (register 0 never creates a dependency)
    assign exReadsHit = (ex_rd != 5'd0) &&
                        ((ex_rd == id_rs) || (id_rt_used && (ex_rd == id_rt)));

`ifdef FWD_EN
    // With forwarding only a load in EX cannot supply its data in time
    assign hazard = id_valid && ex_valid && ex_memrd && exReadsHit;

    // Pick the youngest producer for an EX source register; reg 0 reads as 0
    function automatic logic [31:0] forwardOperand(
        input logic [4:0]  src,
        input logic [31:0] regVal,
        input logic        memWr,
        input logic [4:0]  memDst,
        input logic [31:0] memVal,
        input logic        wbWr,
        input logic [4:0]  wbDst,
        input logic [31:0] wbVal
    );
        logic [31:0] result;
        result = regVal;
        if (src == 5'd0) begin
            result = 32'd0;
        end else if (memWr && (memDst == src)) begin
            result = memVal;
        end else if (wbWr && (wbDst == src)) begin
            result = wbVal;
        end
        return result;
    endfunction

    // Operand muxes sit combinationally on the EX registers
    always_comb begin
        ex_opA = forwardOperand(exRs, exBusA, mem_regwr, mem_rd, mem_result,
                                wb_regwr, wb_rd, wb_result);
        ex_opB = forwardOperand(exRt, exBusB, mem_regwr, mem_rd, mem_result,
                                wb_regwr, wb_rd, wb_result);
    end
`else
    logic memReadsHit;
    logic unusedFwdInputs;

    assign memReadsHit = (mem_rd != 5'd0) &&
                         ((mem_rd == id_rs) || (id_rt_used && (mem_rd == id_rt)));

    // Without forwarding any pending write in EX or MEM blocks the reader;
    // a WB write is visible through the RegFile same-cycle bypass
    assign hazard = id_valid &&
                    ((ex_valid && ex_regwr && exReadsHit) ||
                     (mem_regwr && memReadsHit));

    // No forwarding path: operands come straight from the latched buses
    always_comb begin
        ex_opA = exBusA;
        ex_opB = exBusB;
    end

    assign unusedFwdInputs = ^{mem_result, wb_result, wb_regwr, wb_rd};
`endif

    // A taken branch kills the ID instruction, so it never needs to stall
    assign stall_out  = hazard && !flush && !reset;
    assign loadBubble = flush || stall_out || !id_valid;

    // ID->EX register: reset, then bubble insertion, then normal latch
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_rd    <= 5'd0;
            ex_regwr <= 1'b0;
            ex_memrd <= 1'b0;
            ex_ctrl  <= '0;
            ex_imm   <= 32'd0;
            exRs     <= 5'd0;
            exRt     <= 5'd0;
            exBusA   <= 32'd0;
            exBusB   <= 32'd0;
        end else if (loadBubble) begin
            ex_valid <= 1'b0;
            ex_rd    <= 5'd0;
            ex_regwr <= 1'b0;
            ex_memrd <= 1'b0;
            ex_ctrl  <= '0;
            ex_imm   <= 32'd0;
            exRs     <= 5'd0;
            exRt     <= 5'd0;
            exBusA   <= 32'd0;
            exBusB   <= 32'd0;
        end else begin
            ex_valid <= 1'b1;
            ex_rd    <= id_rd;
            ex_regwr <= id_regwr;
            ex_memrd <= id_memrd;
            ex_ctrl  <= id_ctrl;
            ex_imm   <= id_imm;
            exRs     <= id_rs;
            exRt     <= id_rt;
            exBusA   <= id_busA;
            exBusB   <= id_busB;
        end
    end

    // Profiling counter of stalled cycles, sticks at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_out && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
